// File: rtl/fpu_ss_offload_buffer.sv
// fpu_ss_offload_buffer: completes the core offload handshake from the predecoder
// verdict and buffers accepted instructions in a DEPTH-entry in-order FIFO for issue.
`default_nettype none

module fpu_ss_offload_buffer #(
  parameter int DEPTH   = 4,
  parameter int INSTR_W = 32,
  parameter int XLEN    = 32,
  parameter int ID_W    = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       q_valid_i,
  output logic                       q_ready_o,
  input  logic [INSTR_W-1:0]         q_instr_i,
  input  logic [XLEN-1:0]            q_rs1_i,
  input  logic                       q_rs1_valid_i,
  input  logic [ID_W-1:0]            q_id_i,
  input  logic                       p_accept_i,
  input  logic                       p_writeback_i,
  input  logic                       p_is_mem_op_i,
  input  logic [2:0]                 p_use_rs_i,
  output logic                       p_accept_o,
  output logic                       p_writeback_o,
  output logic                       p_is_mem_op_o,
  output logic                       issue_valid_o,
  input  logic                       issue_ready_i,
  output logic [INSTR_W-1:0]         issue_instr_o,
  output logic [XLEN-1:0]            issue_rs1_o,
  output logic [ID_W-1:0]            issue_id_o,
  output logic                       issue_writeback_o,
  output logic                       issue_is_mem_o,
  output logic [$clog2(DEPTH):0]     fill_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int FILL_W = PTR_W + 1;
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(DEPTH);

  logic [INSTR_W-1:0] r_instr [DEPTH];
  logic [XLEN-1:0]    r_rs1   [DEPTH];
  logic [ID_W-1:0]    r_id    [DEPTH];
  logic               r_wb    [DEPTH];
  logic               r_mem   [DEPTH];

  logic [PTR_W-1:0]   r_wptr;
  logic [PTR_W-1:0]   r_rptr;
  logic [FILL_W-1:0]  r_fill;

  logic               w_full;
  logic               w_empty;
  logic               w_pop;
  logic               w_push_ok;
  logic               w_rs_ok;
  logic               w_hs;
  logic               w_push;
  logic               w_unused_rs;

  // Only rs1 is an integer source for this FPU; rs2/rs3 usage bits are ignored.
  assign w_unused_rs = ^p_use_rs_i[2:1];

  assign w_full    = (r_fill == FILL_MAX);
  assign w_empty   = (r_fill == '0);
  assign w_pop     = !w_empty && issue_ready_i;
  assign w_push_ok = !w_full || w_pop;
  assign w_rs_ok   = !p_use_rs_i[0] || q_rs1_valid_i;

  assign q_ready_o = !flush_i && (p_accept_i ? (w_push_ok && w_rs_ok) : 1'b1);
  assign w_hs      = q_valid_i && q_ready_o;
  assign w_push    = w_hs && p_accept_i;

  assign p_accept_o    = w_hs && p_accept_i;
  assign p_writeback_o = w_hs && p_writeback_i;
  assign p_is_mem_op_o = w_hs && p_is_mem_op_i;

  // Storage is left unreset; the head outputs are masked while the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (w_push && !flush_i) begin
      r_instr[r_wptr] <= q_instr_i;
      r_rs1[r_wptr]   <= p_use_rs_i[0] ? q_rs1_i : '0;
      r_id[r_wptr]    <= q_id_i;
      r_wb[r_wptr]    <= p_writeback_i;
      r_mem[r_wptr]   <= p_is_mem_op_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_fill <= '0;
    end else if (flush_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_fill <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_fill <= r_fill + 1'b1;
        2'b01:   r_fill <= r_fill - 1'b1;
        default: r_fill <= r_fill;
      endcase
    end
  end

  assign issue_valid_o     = !w_empty;
  assign issue_instr_o     = w_empty ? '0   : r_instr[r_rptr];
  assign issue_rs1_o       = w_empty ? '0   : r_rs1[r_rptr];
  assign issue_id_o        = w_empty ? '0   : r_id[r_rptr];
  assign issue_writeback_o = w_empty ? 1'b0 : r_wb[r_rptr];
  assign issue_is_mem_o    = w_empty ? 1'b0 : r_mem[r_rptr];

  assign fill_o  = r_fill;
  assign full_o  = w_full;
  assign empty_o = w_empty;

endmodule

`default_nettype wire

// File: tb/tb_fpu_ss_offload_buffer.sv
// tb_fpu_ss_offload_buffer: directed table vectors plus hand-written corner sequences.
`default_nettype none

module tb_fpu_ss_offload_buffer;

  localparam logic [31:0] FADD_S  = 32'h0000_0053;
  localparam logic [31:0] FMV_W_X = 32'hF000_0053;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        flush_i;
  logic        q_valid_i;
  logic        q_ready_o;
  logic [31:0] q_instr_i;
  logic [31:0] q_rs1_i;
  logic        q_rs1_valid_i;
  logic [3:0]  q_id_i;
  logic        p_accept_i;
  logic        p_writeback_i;
  logic        p_is_mem_op_i;
  logic [2:0]  p_use_rs_i;
  logic        p_accept_o;
  logic        p_writeback_o;
  logic        p_is_mem_op_o;
  logic        issue_valid_o;
  logic        issue_ready_i;
  logic [31:0] issue_instr_o;
  logic [31:0] issue_rs1_o;
  logic [3:0]  issue_id_o;
  logic        issue_writeback_o;
  logic        issue_is_mem_o;
  logic [2:0]  fill_o;
  logic        full_o;
  logic        empty_o;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk_i = ~clk_i;

  fpu_ss_offload_buffer #(.DEPTH(4), .INSTR_W(32), .XLEN(32), .ID_W(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .q_valid_i(q_valid_i), .q_ready_o(q_ready_o), .q_instr_i(q_instr_i),
    .q_rs1_i(q_rs1_i), .q_rs1_valid_i(q_rs1_valid_i), .q_id_i(q_id_i),
    .p_accept_i(p_accept_i), .p_writeback_i(p_writeback_i),
    .p_is_mem_op_i(p_is_mem_op_i), .p_use_rs_i(p_use_rs_i),
    .p_accept_o(p_accept_o), .p_writeback_o(p_writeback_o),
    .p_is_mem_op_o(p_is_mem_op_o), .issue_valid_o(issue_valid_o),
    .issue_ready_i(issue_ready_i), .issue_instr_o(issue_instr_o),
    .issue_rs1_o(issue_rs1_o), .issue_id_o(issue_id_o),
    .issue_writeback_o(issue_writeback_o), .issue_is_mem_o(issue_is_mem_o),
    .fill_o(fill_o), .full_o(full_o), .empty_o(empty_o)
  );

  typedef struct {
    logic        valid;
    logic        accept;
    logic        wb;
    logic        mem;
    logic [2:0]  use_rs;
    logic [31:0] instr;
    logic [31:0] rs1;
    logic        rs1v;
    logic [3:0]  id;
    logic        iready;
    logic        exp_ready;
    logic        exp_pacc;
    logic        exp_pwb;
    logic [2:0]  exp_fill;
    logic        exp_ivalid;
    logic [3:0]  exp_id;
    logic [31:0] exp_rs1;
    logic        exp_hmem;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic offer(input logic v, input logic acc, input logic [2:0] urs,
                       input logic [31:0] ins, input logic [31:0] rs1,
                       input logic rs1v, input logic [3:0] id, input logic irdy);
    q_valid_i     = v;
    p_accept_i    = acc;
    p_use_rs_i    = urs;
    q_instr_i     = ins;
    q_rs1_i       = rs1;
    q_rs1_valid_i = rs1v;
    q_id_i        = id;
    issue_ready_i = irdy;
    p_writeback_i = 1'b0;
    p_is_mem_op_i = 1'b0;
  endtask

  initial begin
    // valid acc wb mem use_rs instr rs1 rs1v id irdy | ready pacc pwb fill ivalid id rs1 hmem
    vecs[0] = '{1,1,0,0,3'b000,FADD_S,32'h0000_1234,1,4'd3,0, 1,1,0,3'd1,1,4'd3,32'h0,0};
    vecs[1] = '{1,1,1,1,3'b001,FADD_S,32'hCAFE_0001,1,4'd5,0, 1,1,1,3'd2,1,4'd3,32'h0,0};
    vecs[2] = '{1,0,0,0,3'b000,FADD_S,32'h0,1,4'd7,0,          1,0,0,3'd2,1,4'd3,32'h0,0};
    vecs[3] = '{1,1,0,0,3'b001,FADD_S,32'hAAAA_0009,0,4'd9,0,  0,0,0,3'd2,1,4'd3,32'h0,0};
    vecs[4] = '{1,1,0,0,3'b001,FADD_S,32'hAAAA_0009,1,4'd9,1,  1,1,0,3'd2,1,4'd5,32'hCAFE_0001,1};
    vecs[5] = '{0,0,0,0,3'b000,FADD_S,32'h0,0,4'd0,1,          1,0,0,3'd1,1,4'd9,32'hAAAA_0009,0};
    vecs[6] = '{0,0,0,0,3'b000,FADD_S,32'h0,0,4'd0,1,          1,0,0,3'd0,0,4'd0,32'h0,0};

    rst_ni  = 1'b0;
    flush_i = 1'b0;
    offer(0, 0, 3'b000, 32'h0, 32'h0, 0, 4'd0, 0);
    #1;
    chk("rst_fill", 64'(fill_o), 64'd0);
    chk("rst_empty", 64'(empty_o), 64'd1);
    chk("rst_full", 64'(full_o), 64'd0);
    chk("rst_ivalid", 64'(issue_valid_o), 64'd0);
    chk("rst_pacc", 64'(p_accept_o), 64'd0);
    chk("rst_instr", 64'(issue_instr_o), 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    for (int i = 0; i < 7; i++) begin
      @(negedge clk_i);
      offer(vecs[i].valid, vecs[i].accept, vecs[i].use_rs, vecs[i].instr,
            vecs[i].rs1, vecs[i].rs1v, vecs[i].id, vecs[i].iready);
      p_writeback_i = vecs[i].wb;
      p_is_mem_op_i = vecs[i].mem;
      #1;
      chk($sformatf("v%0d_qready", i), 64'(q_ready_o), 64'(vecs[i].exp_ready));
      chk($sformatf("v%0d_pacc", i), 64'(p_accept_o), 64'(vecs[i].exp_pacc));
      chk($sformatf("v%0d_pwb", i), 64'(p_writeback_o), 64'(vecs[i].exp_pwb));
      @(posedge clk_i);
      #1;
      chk($sformatf("v%0d_fill", i), 64'(fill_o), 64'(vecs[i].exp_fill));
      chk($sformatf("v%0d_ivalid", i), 64'(issue_valid_o), 64'(vecs[i].exp_ivalid));
      chk($sformatf("v%0d_id", i), 64'(issue_id_o), 64'(vecs[i].exp_id));
      chk($sformatf("v%0d_rs1", i), 64'(issue_rs1_o), 64'(vecs[i].exp_rs1));
      chk($sformatf("v%0d_hmem", i), 64'(issue_is_mem_o), 64'(vecs[i].exp_hmem));
      if (i == 0) chk("v0_instr", 64'(issue_instr_o), 64'(FADD_S));
    end

    // rs1 not yet valid: stall three cycles, then complete.
    @(negedge clk_i);
    offer(1, 1, 3'b001, FMV_W_X, 32'hDEAD_BEEF, 0, 4'd6, 0);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("stall%0d_qready", k), 64'(q_ready_o), 64'd0);
      @(posedge clk_i);
      #1;
      chk($sformatf("stall%0d_fill", k), 64'(fill_o), 64'd0);
      @(negedge clk_i);
    end
    q_rs1_valid_i = 1'b1;
    #1;
    chk("rs1v_qready", 64'(q_ready_o), 64'd1);
    @(posedge clk_i);
    #1;
    chk("rs1v_rs1", 64'(issue_rs1_o), 64'hDEAD_BEEF);
    chk("rs1v_instr", 64'(issue_instr_o), 64'(FMV_W_X));
    @(negedge clk_i);
    offer(0, 0, 3'b000, 32'h0, 32'h0, 0, 4'd0, 1);
    @(posedge clk_i);
    #1;
    chk("rs1v_drain", 64'(empty_o), 64'd1);

    // Fill to capacity with the consumer stalled.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i);
      offer(1, 1, 3'b000, FADD_S, 32'h0, 1, 4'(k), 0);
    end
    @(negedge clk_i);
    chk("full_flag", 64'(full_o), 64'd1);
    chk("full_fill", 64'(fill_o), 64'd4);
    offer(1, 1, 3'b000, FADD_S, 32'h0, 1, 4'd4, 0);
    #1;
    chk("full_stall", 64'(q_ready_o), 64'd0);
    @(negedge clk_i);
    offer(1, 0, 3'b000, 32'hFFFF_FFFF, 32'h0, 1, 4'd15, 0);
    #1;
    chk("full_illegal_qready", 64'(q_ready_o), 64'd1);
    chk("full_illegal_pacc", 64'(p_accept_o), 64'd0);
    @(posedge clk_i);
    #1;
    chk("full_illegal_fill", 64'(fill_o), 64'd4);

    // Full with simultaneous push and pop across pointer wrap.
    for (int k = 0; k < 10; k++) begin
      @(negedge clk_i);
      offer(1, 1, 3'b000, FADD_S, 32'h0, 1, 4'(k + 4), 1);
      #1;
      chk($sformatf("wrap%0d_qready", k), 64'(q_ready_o), 64'd1);
      chk($sformatf("wrap%0d_id", k), 64'(issue_id_o), 64'(k));
      @(posedge clk_i);
      #1;
      chk($sformatf("wrap%0d_fill", k), 64'(fill_o), 64'd4);
    end
    @(negedge clk_i);
    offer(0, 0, 3'b000, 32'h0, 32'h0, 0, 4'd0, 1);
    @(posedge clk_i);
    #1;
    chk("pre_flush_fill", 64'(fill_o), 64'd3);
    chk("pre_flush_head", 64'(issue_id_o), 64'd11);

    // Flush with a push offered.
    @(negedge clk_i);
    offer(1, 1, 3'b000, FADD_S, 32'h0, 1, 4'd14, 0);
    flush_i = 1'b1;
    #1;
    chk("flush_qready", 64'(q_ready_o), 64'd0);
    chk("flush_pacc", 64'(p_accept_o), 64'd0);
    @(posedge clk_i);
    #1;
    chk("flush_fill", 64'(fill_o), 64'd0);
    chk("flush_empty", 64'(empty_o), 64'd1);
    flush_i = 1'b0;

    // Asynchronous reset between edges with two entries held.
    for (int k = 0; k < 2; k++) begin
      @(negedge clk_i);
      offer(1, 1, 3'b000, FADD_S, 32'h0, 1, 4'(k + 1), 0);
    end
    @(negedge clk_i);
    offer(0, 0, 3'b000, 32'h0, 32'h0, 0, 4'd0, 0);
    #1;
    chk("arst_pre_fill", 64'(fill_o), 64'd2);
    #1;
    rst_ni = 1'b0;
    #1;
    chk("arst_ivalid", 64'(issue_valid_o), 64'd0);
    chk("arst_fill", 64'(fill_o), 64'd0);
    chk("arst_id", 64'(issue_id_o), 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fpu_ss_offload_buffer.md
# fpu_ss_offload_buffer

Offload acceptance and buffering stage of the FPU subsystem, directly downstream of the instruction predecoder. It completes the core-side offload handshake using the predecoder's accept/writeback/mem/rs-usage verdict. It captures each accepted instruction with its integer operand and ID into a DEPTH-entry FIFO and presents entries in order to the FPU decoder/issue stage over a valid/ready interface. Rejected instructions complete their handshake immediately and are never buffered.

## Interface
- DEPTH, 4: FIFO entries; power of two, ≥2
- INSTR_W, 32: instruction width
- XLEN, 32: integer operand width
- ID_W, 4: offload ID width
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  synchronous flush of all buffered entries
- q_valid_i  in  1  core offers instruction
- q_ready_o  out  1  handshake completes when q_valid_i && q_ready_o
- q_instr_i  in  INSTR_W  offered instruction, also driven to the predecoder
- q_rs1_i  in  XLEN  integer operand rs1
- q_rs1_valid_i  in  1  q_rs1_i holds valid data
- q_id_i  in  ID_W  offload ID
- p_accept_i  in  1  predecoder verdict for q_instr_i
- p_writeback_i  in  1  predecoder: result returns to integer register file
- p_is_mem_op_i  in  1  predecoder: memory instruction
- p_use_rs_i  in  3  predecoder: rs usage; only bit 0 (rs1) is honoured
- p_accept_o, p_writeback_o, p_is_mem_op_o  out  1 each  response to core, valid in the handshake cycle only
- issue_valid_o  out  1  head entry valid
- issue_ready_i  in  1  downstream consumes head
- issue_instr_o  out  INSTR_W  head instruction
- issue_rs1_o  out  XLEN  head rs1 operand
- issue_id_o  out  ID_W  head ID
- issue_writeback_o, issue_is_mem_o  out  1 each  head predecoder flags
- fill_o  out  $clog2(DEPTH)+1  occupied entries
- full_o, empty_o  out  1 each  fill_o==DEPTH / fill_o==0

## Operation
- push_ok = !full_o || (issue_valid_o && issue_ready_i).
- rs_ok = !p_use_rs_i[0] || q_rs1_valid_i.
- q_ready_o = !flush_i && (p_accept_i ? (push_ok && rs_ok) : 1).
- Rejected instruction (p_accept_i=0): handshake completes at once, even when full; p_accept_o=0, nothing stored.
- Accepted handshake: push {q_instr_i, q_rs1_i if p_use_rs_i[0] else 0, q_id_i, p_writeback_i, p_is_mem_op_i} at the write pointer.
- p_*_o mirror p_*_i while q_valid_i && q_ready_o; otherwise 0.
- Pop when issue_valid_o && issue_ready_i; the read pointer advances.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. fill_o is a separate counter: +1 on push only, −1 on pop only, unchanged on simultaneous push and pop.
- flush_i: pointers and fill reset to 0 next edge; overrides any push or pop in the same cycle. No handshake completes while flush_i=1.
- No fall-through: a pushed entry is visible at issue_valid_o the cycle after the push, never in the same cycle.
- Order is strict FIFO. No reordering or skipping.

## Timing
- Reset (rst_ni=0, asynchronous): pointers and fill_o=0, empty_o=1, full_o=0, issue_valid_o=0, p_*_o=0. issue_* data outputs are 0.
- Latency: handshake at edge N gives issue_valid_o=1 from cycle N+1 when the FIFO was empty.
- Throughput: 1 push + 1 pop per cycle sustained, including at full.
- Combinational paths: q_instr_i→predecoder→q_ready_o/p_*_o, and issue_ready_i→q_ready_o. No path from q_* to issue_*.
- Empty with simultaneous push: no pop occurs; fill_o becomes 1.
- Full with no pop: accepted instructions stall (q_ready_o=0); rejected ones still complete.
- rs1 not valid: accepted instruction stalls until q_rs1_valid_i=1. Core must hold q_* stable while q_valid_i && !q_ready_o.
- Reset asserted mid-operation: entries discarded immediately; outputs go to their reset values without waiting for a clock edge.

## Test plan
- Reset, then push FADD_S (accept=1, use_rs=000, id=3) → issue_valid_o=1 next cycle, issue_id_o=3, issue_rs1_o=0, fill_o=1.
- Push FMV_W_X with rs1=0xDEADBEEF and rs1_valid=0 for 3 cycles, then 1 → q_ready_o=0 for 3 cycles; the entry then carries rs1 0xDEADBEEF.
- DEPTH=4, issue_ready_i=0: push 4 accepted instructions → full_o=1. A 5th accepted instruction stalls. An illegal instruction (accept=0) completes with p_accept_o=0 and fill_o stays 4.
- Full, with issue_ready_i=1 and a push in the same cycle → q_ready_o=1, fill_o stays 4. Run 10 cycles of this → IDs pop in order across pointer wrap.
- 3 entries plus flush_i=1 with a push offered → q_ready_o=0; next cycle fill_o=0, empty_o=1.
- rst_ni pulled low between edges with 2 entries held → issue_valid_o=0 and fill_o=0 immediately.
